// File: rtl/eu_dispatch_steer.sv
// Round-robin dispatch steering from rename to NUM_EU execution units, gated by
// per-EU credit counters that mirror each EU's IQueue occupancy.
module eu_dispatch_steer #(
    parameter int NUM_EU   = 4,
    parameter int IQ_DEPTH = 4,
    parameter int INSTR_W  = 32,
    localparam int IDX_W   = (NUM_EU > 1) ? $clog2(NUM_EU) : 1,
    localparam int CW      = $clog2(IQ_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [INSTR_W-1:0] disp_instr_o,
    output logic [NUM_EU-1:0]  disp_valid_o,
    output logic [IDX_W-1:0]   disp_eu_idx_o,
    input  logic [NUM_EU-1:0]  eu_retire_i,
    output logic               credit_err_o
);

    logic [CW-1:0]      credit_q [NUM_EU];
    logic [CW-1:0]      credit_d [NUM_EU];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [INSTR_W-1:0] disp_instr_q, disp_instr_d;
    logic [NUM_EU-1:0]  disp_valid_q, disp_valid_d;
    logic [IDX_W-1:0]   disp_idx_q, disp_idx_d;
    logic               err_q, err_d;

    logic [NUM_EU-1:0]  avail;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W:0]     cand;
    logic               found;
    logic               fire;
    logic               dec;

    always_comb begin
        for (int e = 0; e < NUM_EU; e++) begin
            avail[e] = (credit_q[e] != '0);
        end
    end

    // Search starts at rr_ptr and wraps explicitly, so NUM_EU need not be a power of two.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_EU; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_EU)) begin
                cand = cand - (IDX_W+1)'(NUM_EU);
            end
            if (!found && avail[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    assign in_ready_o = !flush_i && (|avail);
    assign fire       = in_valid_i && in_ready_o;

    always_comb begin
        err_d = err_q;
        dec   = 1'b0;
        for (int e = 0; e < NUM_EU; e++) begin
            credit_d[e] = credit_q[e];
            if (flush_i) begin
                credit_d[e] = CW'(IQ_DEPTH);
            end else begin
                dec = fire && (sel == IDX_W'(e));
                if (eu_retire_i[e] && !dec) begin
                    if (credit_q[e] == CW'(IQ_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        credit_d[e] = credit_q[e] + CW'(1);
                    end
                end else if (dec && !eu_retire_i[e]) begin
                    credit_d[e] = credit_q[e] - CW'(1);
                end
            end
        end
    end

    // Strobe is a one-cycle pulse; instruction and index hold between dispatches.
    always_comb begin
        disp_valid_d = '0;
        disp_instr_d = disp_instr_q;
        disp_idx_d   = disp_idx_q;
        rr_ptr_d     = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (fire) begin
            for (int e = 0; e < NUM_EU; e++) begin
                disp_valid_d[e] = (sel == IDX_W'(e));
            end
            disp_instr_d = in_instr_i;
            disp_idx_d   = sel;
            rr_ptr_d     = (sel == IDX_W'(NUM_EU - 1)) ? '0 : sel + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < NUM_EU; e++) begin
                credit_q[e] <= CW'(IQ_DEPTH);
            end
            rr_ptr_q     <= '0;
            disp_instr_q <= '0;
            disp_valid_q <= '0;
            disp_idx_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_EU; e++) begin
                credit_q[e] <= credit_d[e];
            end
            rr_ptr_q     <= rr_ptr_d;
            disp_instr_q <= disp_instr_d;
            disp_valid_q <= disp_valid_d;
            disp_idx_q   <= disp_idx_d;
            err_q        <= err_d;
        end
    end

    assign disp_instr_o  = disp_instr_q;
    assign disp_valid_o  = disp_valid_q;
    assign disp_eu_idx_o = disp_idx_q;
    assign credit_err_o  = err_q;

endmodule
